// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin decode arbiter.
// The master side drives req/done; the arbiter (slave) returns the decoder select and grant.
interface rr_decode_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic       en;
    logic [7:0] gnt;
    logic       busy;

    modport master (
        output req,
        output done,
        input  sel,
        input  en,
        input  gnt,
        input  busy
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output en,
        output gnt,
        output busy
    );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Eight-way round-robin arbiter driving a 3:8 decoder select with one-hot grant.
// Optional grant timeout enabled by defining ARB_TIMEOUT_EN (limit set by HOLD_CYCLES).
//
// state | meaning
// IDLE  | no grant, waiting for any request
// GRANT | sel owns the resource until done, request drop or timeout
// GAP   | one dead cycle after a release; arbitration runs again here
module rr_decode_arbiter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rr_decode_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("rr_decode_arbiter: HOLD_CYCLES must be in 1..255");
    end

    state_t     state;
    state_t     state_nxt;
    logic [2:0] ptr;
    logic [2:0] ptr_nxt;
    logic [2:0] sel_q;
    logic [2:0] sel_nxt;
    logic       en_q;
    logic       en_nxt;
    logic [7:0] gnt_q;
    logic [7:0] gnt_nxt;
    logic       busy_q;
    logic       busy_nxt;

    logic       found;
    logic [2:0] winner;
    logic [2:0] scan_idx;
    logic       timeout;
    logic       release_c;

    // First set request at or after ptr, wrapping modulo 8.
    always_comb begin
        found    = 1'b0;
        winner   = ptr;
        scan_idx = ptr;
        for (int k = 0; k < 8; k++) begin
            scan_idx = ptr + 3'(k);
            if (!found && bus.req[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_nxt;

    assign timeout = (hold_cnt == 8'(HOLD_CYCLES - 1));

    // Zero on grant entry and outside GRANT, so only a continuing grant counts up.
    always_comb begin
        hold_cnt_nxt = 8'd0;
        if (state == GRANT && state_nxt == GRANT) begin
            hold_cnt_nxt = hold_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 8'd0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign release_c = bus.done | ~bus.req[sel_q] | timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= 3'd0;
            sel_q  <= 3'd0;
            en_q   <= 1'b0;
            gnt_q  <= 8'h00;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            sel_q  <= sel_nxt;
            en_q   <= en_nxt;
            gnt_q  <= gnt_nxt;
            busy_q <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = GRANT;
            GRANT:   if (release_c) state_nxt = GAP;
            GAP:     state_nxt = found ? GRANT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next registered outputs; sel and ptr only move when a new grant is taken.
    always_comb begin
        sel_nxt  = sel_q;
        ptr_nxt  = ptr;
        en_nxt   = 1'b0;
        busy_nxt = (state_nxt != IDLE);
        if (state_nxt == GRANT) begin
            en_nxt = 1'b1;
            if (state != GRANT) begin
                sel_nxt = winner;
                ptr_nxt = winner + 3'd1;
            end
        end
        gnt_nxt = en_nxt ? (8'd1 << sel_nxt) : 8'h00;
    end

    assign bus.sel  = sel_q;
    assign bus.en   = en_q;
    assign bus.gnt  = gnt_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter: a transaction-level arbitration model checked every
// cycle, plus literal expectations for the reference scenarios.
module tb_rr_decode_arbiter;

    localparam int HOLD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_decode_arbiter_if bus ();

    rr_decode_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: who owns the resource, whether a dead cycle follows, where the rotation starts,
    // and how many cycles the current owner has been visible.
    bit m_active = 1'b0;
    bit m_gap    = 1'b0;
    int m_owner  = 0;
    int m_ptr    = 0;
    int m_held   = 0;
    bit m_rel;
    int m_w;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_gap    = 1'b0;
            m_owner  = 0;
            m_ptr    = 0;
            m_held   = 0;
        end else if (m_active) begin
            m_rel = bus.done || !bus.req[m_owner];
`ifdef ARB_TIMEOUT_EN
            if (m_held >= HOLD) m_rel = 1'b1;
`endif
            if (m_rel) begin
                m_active = 1'b0;
                m_gap    = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            m_gap = 1'b0;
            m_w   = pick(bus.req, m_ptr);
            if (m_w >= 0) begin
                m_active = 1'b1;
                m_owner  = m_w;
                m_ptr    = (m_w + 1) % 8;
                m_held   = 1;
            end
        end
    end

    logic [7:0] exp_gnt;
    logic [2:0] exp_sel;
    logic       exp_busy;

    always @(posedge clk) begin
        #1;
        exp_gnt  = m_active ? (8'h01 << m_owner) : 8'h00;
        exp_sel  = 3'(m_owner);
        exp_busy = m_active | m_gap;
        n_vec++;
        if (bus.gnt !== exp_gnt || bus.sel !== exp_sel || bus.en !== m_active || bus.busy !== exp_busy) begin
            n_err++;
            $display("FAIL cycle_check t=%0t: got sel=%0d en=%0b gnt=%h busy=%0b, want sel=%0d en=%0b gnt=%h busy=%0b",
                     $time, bus.sel, bus.en, bus.gnt, bus.busy, exp_sel, m_active, exp_gnt, exp_busy);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s t=%0t: got %h want %h", name, $time, act, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [8:0] tbl [16] = '{9'h0FF, 9'h0FF, 9'h1FF, 9'h0F0, 9'h0F0, 9'h00F, 9'h10F, 9'h081,
                             9'h081, 9'h000, 9'h0C3, 9'h1C3, 9'h03C, 9'h100, 9'h0AA, 9'h055};
    logic [7:0] lit;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req  = 8'h00;
        bus.done = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sel",  {5'd0, bus.sel},  8'h00);
        chk("rst_en",   {7'd0, bus.en},   8'h00);
        chk("rst_gnt",  bus.gnt,          8'h00);
        chk("rst_busy", {7'd0, bus.busy}, 8'h00);
        rst_n = 1'b1;

        // Two requesters alternate, one dead cycle between grants.
        bus.req = 8'h05;
        @(negedge clk); chk("a_gnt0", bus.gnt, 8'h01); chk("a_sel0", {5'd0, bus.sel}, 8'h00); bus.done = 1'b1;
        @(negedge clk); bus.done = 1'b0; chk("a_gap1", bus.gnt, 8'h00); chk("a_gap1_busy", {7'd0, bus.busy}, 8'h01);
        @(negedge clk); chk("a_gnt2", bus.gnt, 8'h04); chk("a_sel2", {5'd0, bus.sel}, 8'h02); bus.done = 1'b1;
        @(negedge clk); bus.done = 1'b0; chk("a_gap2", bus.gnt, 8'h00);
        @(negedge clk); chk("a_gnt0b", bus.gnt, 8'h01); chk("a_sel0b", {5'd0, bus.sel}, 8'h00); bus.done = 1'b1;
        @(negedge clk); bus.done = 1'b0; bus.req = 8'h00; chk("a_gap3", bus.gnt, 8'h00); chk("a_gap3_sel", {5'd0, bus.sel}, 8'h00);
        @(negedge clk); chk("a_idle_busy", {7'd0, bus.busy}, 8'h00);

`ifdef ARB_TIMEOUT_EN
        // All requesting, no done: each grant times out after HOLD cycles and rotates.
        do_reset();
        bus.req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            lit = 8'h01 << (g % 8);
            for (int c = 0; c < HOLD; c++) begin
                @(negedge clk); chk("b_hold_gnt", bus.gnt, lit);
            end
            @(negedge clk); chk("b_gap_gnt", bus.gnt, 8'h00);
        end
        bus.req = 8'h00;
        repeat (2) @(negedge clk);
`else
        // Without timeout a held request keeps its grant indefinitely.
        do_reset();
        bus.req = 8'h08;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("c_gnt", bus.gnt, 8'h08);
            chk("c_sel", {5'd0, bus.sel}, 8'h03);
            chk("c_en",  {7'd0, bus.en},  8'h01);
        end
        bus.req = 8'h00;
        @(negedge clk); chk("c_gap_en", {7'd0, bus.en}, 8'h00); chk("c_gap_busy", {7'd0, bus.busy}, 8'h01);
        @(negedge clk); chk("c_idle_busy", {7'd0, bus.busy}, 8'h00);
`endif

        // Asynchronous reset in the middle of a grant.
        do_reset();
        bus.req = 8'h20;
        @(negedge clk); chk("d_gnt5", bus.gnt, 8'h20);
        #2 rst_n = 1'b0;
        #1;
        chk("d_async_en",   {7'd0, bus.en},   8'h00);
        chk("d_async_gnt",  bus.gnt,          8'h00);
        chk("d_async_busy", {7'd0, bus.busy}, 8'h00);
        chk("d_async_sel",  {5'd0, bus.sel},  8'h00);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); chk("d_regnt5", bus.gnt, 8'h20); chk("d_regnt5_sel", {5'd0, bus.sel}, 8'h05);
        bus.req = 8'h00;
        repeat (2) @(negedge clk);

        // done and req drop together: a single release, then the next requester.
        do_reset();
        bus.req = 8'h42;
        @(negedge clk); chk("e_gnt1", bus.gnt, 8'h02); bus.done = 1'b1; bus.req = 8'h40;
        @(negedge clk); bus.done = 1'b0; chk("e_gap", bus.gnt, 8'h00); chk("e_gap_busy", {7'd0, bus.busy}, 8'h01);
        @(negedge clk); chk("e_gnt6", bus.gnt, 8'h40); chk("e_sel6", {5'd0, bus.sel}, 8'h06);
        bus.req = 8'h00;
        repeat (2) @(negedge clk);

        // Mixed request/done patterns, checked cycle by cycle against the model.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                bus.done = tbl[i][8];
                bus.req  = tbl[i][7:0];
                @(negedge clk);
            end
        end
        bus.req  = 8'h00;
        bus.done = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_decode_arbiter.md
RR_DECODE_ARBITER -- requirements
Module: rr_decode_arbiter

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, maximum cycles one grant is held, legal range 1..255.
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  8  request per requester; bit i = requester i.
REQ-005 Port: done  input  1  current owner releases the resource; sampled only in GRANT.
REQ-006 Port: sel  output  3  binary index of the granted requester; drives the 3:8 decoder select.
REQ-007 Port: en  output  1  decoder enable; 1 only while a grant is active.
REQ-008 Port: gnt  output  8  one-hot grant, equal to en ? (1 << sel) : 8'h00.
REQ-009 Port: busy  output  1  1 whenever the state is not IDLE.

Function
REQ-010 The FSM SHALL have three states: IDLE, GRANT, GAP; all outputs registered.
REQ-011 Round-robin pointer ptr (3 bits) SHALL define search order ptr, ptr+1, ... ptr+7, modulo 8.
REQ-012 IDLE: if req != 0, the first set bit in search order SHALL be granted at the next edge (sel=index, en=1, state GRANT). One-cycle latency.
REQ-013 On each grant to index i, ptr SHALL become (i+1) mod 8; i=7 wraps ptr to 0.
REQ-014 GRANT: hold counter SHALL clear to 0 on grant entry and increment once per GRANT cycle.
REQ-015 GRANT SHALL release (next state GAP, en=0) when any of these holds: done=1, req[sel]=0, or timeout (REQ-023).
REQ-016 Simultaneous release causes SHALL produce exactly one release; same cycle, no double-count.
REQ-017 GAP SHALL last exactly one cycle with en=0, gnt=0; arbitration per REQ-012 runs in GAP: any req -> GRANT next edge, else IDLE.
REQ-018 A released requester still requesting SHALL be reconsidered only after all others in rotation order (fairness via ptr).
REQ-019 sel SHALL hold its last granted value while en=0.
REQ-020 done in IDLE or GAP SHALL be ignored.
REQ-021 req changes in GRANT other than req[sel] SHALL not affect the current grant.

Reset
REQ-022 rst_n=0 SHALL immediately (asynchronously) force state IDLE, ptr=0, counter=0, sel=3'd0, en=0, gnt=8'h00, busy=0, including mid-grant; first arbitration occurs at the first rising clk edge after rst_n rises.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN defined: GRANT SHALL release when counter == HOLD_CYCLES-1, so a grant lasts at most HOLD_CYCLES cycles.
REQ-024 Macro ARB_TIMEOUT_EN undefined: no timeout; grant lasts until done=1 or req[sel]=0; counter logic absent; HOLD_CYCLES unused.

Verification
REQ-025 Reset then req=8'b0000_0101 held, done pulsed 1 cycle in each grant -> grants to 0, then 2, then 0; each grant separated by exactly one gnt=0 cycle; sel=0,2,0.
REQ-026 ARB_TIMEOUT_EN, HOLD_CYCLES=4, req=8'hFF, done=0 -> gnt 8'h01 for 4 cycles, 1 gap, 8'h02 for 4 cycles, ... 8'h80, then wraps to 8'h01.
REQ-027 Without ARB_TIMEOUT_EN, req=8'h08 held 20 cycles, done=0 -> gnt=8'h08, sel=3, en=1 for all 20 cycles; then req=0 -> one GAP cycle, then IDLE, busy=0.
REQ-028 During grant to 5 (gnt=8'h20), drive rst_n=0 between clock edges -> en, gnt, busy go 0 and sel=0 without a clock edge; after release, req=8'h20 grants 5 again one cycle later.
REQ-029 In GRANT to 1, assert done and drop req[1] in the same cycle while req[6]=1 -> single GAP cycle, then gnt=8'h40, sel=6.
